// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider (div_seq).
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and HI/LO result bus between the MIPS control path and div_seq.
interface div_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < dvs always holds, so the (WIDTH+1)-bit difference borrows exactly when shifted < dvs
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to lo, remainder to hi, flags b==0.
// Optional macro DIV_FAST_PATH_EN: skip iteration when |a| < |b| (nonzero b).
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;

    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // Operand magnitudes; MIN negates to itself, which reads correctly as unsigned 2^(WIDTH-1)
    always_comb begin
        a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[cnt]),
        .dvs     (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            b_zero     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd        <= a_mag;
                        dvs        <= b_mag;
                        rem        <= '0;
                        quo        <= '0;
                        q_neg      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg      <= bus.is_signed & bus.a[WIDTH-1];
                        b_zero     <= (bus.b == '0);
                        div_zero_r <= 1'b0;
                        busy_r     <= 1'b1;
                        cnt        <= CNT_W'(WIDTH - 1);
                        if (bus.b == '0) begin
                            state <= FINISH;
`ifdef DIV_FAST_PATH_EN
                        end else if (a_mag < b_mag) begin
                            state <= FINISH;
                            rem   <= a_mag;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem      <= step_rem;
                    quo[cnt] <= step_q;
                    if (cnt == '0) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                FINISH: begin
                    if (b_zero) begin
                        div_zero_r <= 1'b1;
                    end else begin
                        lo_r <= q_neg ? -quo : quo;
                        hi_r <= r_neg ? -rem : rem;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: vector table plus handshake corner sequences.
module tb_div_seq;
    import div_pkg::*;

    localparam int unsigned W        = 32;
    localparam int          LAT_FULL = W + 1;
    localparam int          LAT_ZERO = 1;
`ifdef DIV_FAST_PATH_EN
    localparam int          LAT_SMALL = 1;
`else
    localparam int          LAT_SMALL = W + 1;
`endif

    logic clk = 1'b0;
    logic reset;

    div_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[12];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Present operands for one edge; returns #1 after the accepting edge
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.a         = a;
        bus.b         = b;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    // Edges until done is seen; -1 on timeout
    task automatic wait_done(input int max_edges, output int lat);
        lat = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                return;
            end
        end
    endtask

    // Counts edges on which done or busy is high over a quiet window
    task automatic quiet_window(input int edges, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int n_busy;

        vecs[0]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, LAT_FULL};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, LAT_SMALL};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, LAT_FULL};
        vecs[4]  = '{1'b0, 32'd100,       32'h8000_0000, 32'h0000_0000, 32'd100,       1'b0, LAT_SMALL};
        vecs[5]  = '{1'b0, 32'd9,         32'd2,         32'd4,         32'd1,         1'b0, LAT_FULL};
        vecs[6]  = '{1'b0, 32'd5,         32'd0,         32'd4,         32'd1,         1'b1, LAT_ZERO};
        vecs[7]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, LAT_FULL};
        vecs[8]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0, LAT_SMALL};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE, 1'b0, LAT_FULL};
        vecs[10] = '{1'b1, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0, LAT_FULL};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0, LAT_FULL};

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_done", bus.done, 1'b0);
        check_bit("reset_dz",   bus.div_zero, 1'b0);
        check("reset_hi", bus.hi, '0);
        check("reset_lo", bus.lo, '0);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
            check_bit($sformatf("v%0d_busy_start", i), bus.busy, 1'b1);
            wait_done(40, lat);
            check_int($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            check_bit($sformatf("v%0d_dz", i), bus.div_zero, vecs[i].dz);
            check_bit($sformatf("v%0d_busy_done", i), bus.busy, 1'b0);
        end

        // start pulsed at iteration 5 must not disturb the running operation
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd100;
        bus.b         = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(40, lat);
        check_int("ign_latency", (lat < 0) ? -1 : lat + 5, LAT_FULL);
        check("ign_lo", bus.lo, 32'hFFFF_FFFD);
        check("ign_hi", bus.hi, 32'hFFFF_FFFF);
        quiet_window(40, n_done, n_busy);
        check_int("ign_extra_done", n_done, 0);
        check_int("ign_extra_busy", n_busy, 0);

        // start held through done: the next operation is accepted on the following edge
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd9;
        bus.b         = 32'd2;
        @(posedge clk); #1;
        bus.a = 32'd20;
        bus.b = 32'd3;
        wait_done(40, lat);
        check_int("b2b_lat1", lat, LAT_FULL);
        check("b2b_lo1", bus.lo, 32'd4);
        check("b2b_hi1", bus.hi, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_bit("b2b_busy2", bus.busy, 1'b1);
        check_bit("b2b_done2", bus.done, 1'b0);
        wait_done(40, lat);
        check_int("b2b_lat2", lat, LAT_FULL);
        check("b2b_lo2", bus.lo, 32'd6);
        check("b2b_hi2", bus.hi, 32'd2);

        // reset at iteration 10 aborts the operation and clears results
        start_op(1'b0, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        quiet_window(40, n_done, n_busy);
        check_int("rst_no_done", n_done, 0);
        check_int("rst_no_busy", n_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
